// File: rtl/axi_pkt_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : axi_pkt_rr_arbiter_if
// Stream bundle between N requester ports and the shared output of the arbiter.
// Rev    : 1.0
// ============================================================================
interface axi_pkt_rr_arbiter_if #(
    parameter int NUM_INPUTS = 4,
    parameter int WIDTH      = 64
);
    logic [NUM_INPUTS*WIDTH-1:0] i_tdata;
    logic [NUM_INPUTS-1:0]       i_tlast;
    logic [NUM_INPUTS-1:0]       i_tvalid;
    logic [NUM_INPUTS-1:0]       i_tready;
    logic [WIDTH-1:0]            o_tdata;
    logic                        o_tlast;
    logic                        o_tvalid;
    logic                        o_tready;

    // Environment side: sources the requests and sinks the merged stream.
    modport master (
        output i_tdata, i_tlast, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tlast, o_tvalid
    );

    // Arbiter side.
    modport slave (
        input  i_tdata, i_tlast, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tlast, o_tvalid
    );
endinterface

`default_nettype wire

// File: rtl/axi_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axi_pkt_rr_arbiter
// Packet-granular round-robin merge of NUM_INPUTS (2..4) streams onto one.
// Rev    : 1.0
// ============================================================================
module axi_pkt_rr_arbiter #(
    parameter int         NUM_INPUTS = 4,
    parameter int         WIDTH      = 64,
    parameter logic [7:0] SR_ENABLE  = 8'd0
) (
    input  wire                 bus_clk,
    input  wire                 bus_rst,
    input  wire                 clear,
    input  wire                 set_stb,
    input  wire  [7:0]          set_addr,
    input  wire  [31:0]         set_data,
    axi_pkt_rr_arbiter_if.slave axis,
    output logic [1:0]          grant_port,
    output logic                busy,
    output logic [31:0]         pkt_count
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Last grant parks on the top port so the first search begins at port 0.
    localparam logic [1:0] c_LAST_GRANT_RST = 2'(NUM_INPUTS - 1);

    state_t                r_state;
    logic [1:0]            r_last_grant;
    logic [1:0]            r_grant_port;
    logic [NUM_INPUTS-1:0] r_enable;
    logic [31:0]           r_pkt_count;

    logic [NUM_INPUTS-1:0] w_cand;
    logic                  w_found;
    logic [1:0]            w_next;
    logic [1:0]            w_scan;
    logic                  w_pkt_done;
    logic                  w_unused;

    assign w_unused = ^set_data;

    // Cyclic search starting one past the previous winner.
    always_comb begin
        w_cand  = axis.i_tvalid & r_enable;
        w_found = 1'b0;
        w_next  = '0;
        w_scan  = '0;
        for (int k = 1; k <= NUM_INPUTS; k++) begin
            w_scan = 2'((int'(r_last_grant) + k) % NUM_INPUTS);
            if (!w_found && w_cand[w_scan]) begin
                w_found = 1'b1;
                w_next  = w_scan;
            end
        end
    end

    always_comb begin
        axis.i_tready = '0;
        axis.o_tdata  = axis.i_tdata[int'(r_grant_port)*WIDTH +: WIDTH];
        axis.o_tlast  = 1'b0;
        axis.o_tvalid = 1'b0;
        if (r_state == GRANT) begin
            axis.o_tlast                = axis.i_tlast[r_grant_port];
            axis.o_tvalid               = axis.i_tvalid[r_grant_port];
            axis.i_tready[r_grant_port] = axis.o_tready;
        end
    end

    assign w_pkt_done = axis.o_tvalid & axis.o_tready & axis.o_tlast;

    // Mask is only sampled in IDLE, so a mid-packet disable never aborts a packet.
    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_state      <= IDLE;
            r_last_grant <= c_LAST_GRANT_RST;
            r_grant_port <= '0;
            r_pkt_count  <= '0;
            r_enable     <= '1;
        end else begin
            if (set_stb && (set_addr == SR_ENABLE)) begin
                r_enable <= set_data[NUM_INPUTS-1:0];
            end
            if (clear) begin
                r_state      <= IDLE;
                r_last_grant <= c_LAST_GRANT_RST;
                r_grant_port <= '0;
                r_pkt_count  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_found) begin
                            r_grant_port <= w_next;
                            r_state      <= GRANT;
                        end
                    end
                    GRANT: begin
                        if (w_pkt_done) begin
                            r_state      <= IDLE;
                            r_last_grant <= r_grant_port;
                            r_pkt_count  <= r_pkt_count + 32'd1;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign grant_port = r_grant_port;
    assign busy       = (r_state == GRANT);
    assign pkt_count  = r_pkt_count;

endmodule

`default_nettype wire

// File: tb/tb_axi_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_pkt_rr_arbiter
// Self-checking bench: per-port packet sources, output scoreboard, scenario table.
// Rev    : 1.0
// ============================================================================
module tb_axi_pkt_rr_arbiter;

    localparam int         NI = 4;
    localparam int         W  = 64;
    localparam logic [7:0] SR = 8'h10;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [1:0]  port;
        logic [63:0] data;
        logic        last;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [3:0] present;
        int         beats;
        int         npkts;
        logic [15:0] order;
        int         exp_n;
    } scen_t;

    logic        bus_clk;
    logic        bus_rst;
    logic        clear;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [1:0]  grant_port;
    logic        busy;
    logic [31:0] pkt_count;

    axi_pkt_rr_arbiter_if #(.NUM_INPUTS(NI), .WIDTH(W)) ifc ();

    axi_pkt_rr_arbiter #(.NUM_INPUTS(NI), .WIDTH(W), .SR_ENABLE(SR)) dut (
        .bus_clk    (bus_clk),
        .bus_rst    (bus_rst),
        .clear      (clear),
        .set_stb    (set_stb),
        .set_addr   (set_addr),
        .set_data   (set_data),
        .axis       (ifc.slave),
        .grant_port (grant_port),
        .busy       (busy),
        .pkt_count  (pkt_count)
    );

    beat_t port_q[NI][$];
    exp_t  sb[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc      = 0;
    int    sc_first = -1;
    int    sc_last  = -1;
    bit    gap_pending = 0;

    initial begin
        bus_clk = 1'b0;
        forever #5 bus_clk = ~bus_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] mk_data(input int port, input int pkt, input int beat);
        return {16'hCAFE, 16'(port), 16'(pkt), 16'(beat)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge bus_clk);
        #1;
    endtask

    task automatic queue_pkt(input int port, input int n, input int pkt);
        for (int b = 0; b < n; b++) port_q[port].push_back('{mk_data(port, pkt, b), (b == n - 1)});
    endtask

    task automatic expect_beat(input int port, input int pkt, input int beat, input logic last);
        sb.push_back('{2'(port), mk_data(port, pkt, beat), last});
    endtask

    task automatic expect_pkt(input int port, input int n, input int pkt);
        for (int b = 0; b < n; b++) expect_beat(port, pkt, b, (b == n - 1));
    endtask

    task automatic do_reset();
        tick();
        bus_rst  = 1'b1;
        clear    = 1'b0;
        set_stb  = 1'b0;
        ifc.o_tready = 1'b1;
        for (int k = 0; k < NI; k++) port_q[k].delete();
        sb.delete();
        tick();
        tick();
        bus_rst = 1'b0;
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [31:0] data);
        tick();
        set_stb  = 1'b1;
        set_addr = addr;
        set_data = data;
        tick();
        set_stb  = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge bus_clk);
            n++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL %s drain: %0d beats outstanding after %0d cycles, required 0", name, sb.size(), n);
            sb.delete();
        end
    endtask

    task automatic wait_busy(input string name);
        int n = 0;
        @(negedge bus_clk);
        while (busy !== 1'b1 && n < 20) begin
            @(negedge bus_clk);
            n++;
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s grant: busy=%b after 20 cycles, required 1", name, busy);
        end
    endtask

    // Request sources: a beat leaves its queue once it was handshaken at the edge.
    initial begin
        logic [NI-1:0] hs;
        ifc.i_tdata  = '0;
        ifc.i_tlast  = '0;
        ifc.i_tvalid = '0;
        forever begin
            @(negedge bus_clk);
            hs = ifc.i_tvalid & ifc.i_tready;
            @(posedge bus_clk);
            #2;
            for (int k = 0; k < NI; k++) begin
                if (hs[k] && port_q[k].size() > 0) void'(port_q[k].pop_front());
                if (port_q[k].size() > 0) begin
                    ifc.i_tdata[k*W +: W] = port_q[k][0].data;
                    ifc.i_tlast[k]        = port_q[k][0].last;
                    ifc.i_tvalid[k]       = 1'b1;
                end else begin
                    ifc.i_tlast[k]  = 1'b0;
                    ifc.i_tvalid[k] = 1'b0;
                end
            end
        end
    end

    // Output monitor: every accepted beat must match the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge bus_clk);
            cyc++;
            if (gap_pending) begin
                gap_pending = 0;
                check("idle gap o_tvalid", 64'(ifc.o_tvalid), 64'd0);
            end
            if (ifc.o_tvalid === 1'b1 && ifc.o_tready === 1'b1) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected beat: port %0d data 0x%0h, required no output", grant_port, ifc.o_tdata);
                end else begin
                    e = sb.pop_front();
                    if (grant_port !== e.port || ifc.o_tdata !== e.data || ifc.o_tlast !== e.last) begin
                        n_errors++;
                        $display("FAIL out beat: got port %0d data 0x%0h last %b, expected port %0d data 0x%0h last %b",
                                 grant_port, ifc.o_tdata, ifc.o_tlast, e.port, e.data, e.last);
                    end
                end
                if (sc_first < 0) sc_first = cyc;
                if (ifc.o_tlast === 1'b1) begin
                    sc_last     = cyc;
                    gap_pending = 1;
                end
            end
        end
    end

    scen_t vec[6];

    initial begin
        int nid[NI];
        int p;
        vec[0] = '{"four ports 3-beat",  4'hF, 4'hF, 3, 1, 16'h00E4, 4};
        vec[1] = '{"port2 single beats", 4'hF, 4'h4, 1, 5, 16'hAAAA, 5};
        vec[2] = '{"mask 1010",          4'hA, 4'hF, 2, 2, 16'h00DD, 4};
        vec[3] = '{"ports 0 and 3",      4'hF, 4'h9, 1, 2, 16'h00CC, 4};
        vec[4] = '{"mask 0110",          4'h6, 4'hF, 1, 1, 16'h0009, 2};
        vec[5] = '{"mask all off",       4'h0, 4'hF, 2, 1, 16'h0000, 0};

        bus_rst  = 1'b1;
        clear    = 1'b0;
        set_stb  = 1'b0;
        set_addr = '0;
        set_data = '0;
        ifc.o_tready = 1'b1;

        // Reset values, with a request already pending on port 1.
        queue_pkt(1, 2, 0);
        expect_pkt(1, 2, 0);
        repeat (3) @(posedge bus_clk);
        @(negedge bus_clk);
        check("reset i_tready", 64'(ifc.i_tready), 64'd0);
        check("reset o_tvalid", 64'(ifc.o_tvalid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset grant_port", 64'(grant_port), 64'd0);
        check("reset pkt_count", 64'(pkt_count), 64'd0);
        tick();
        bus_rst = 1'b0;
        @(negedge bus_clk);
        check("post-reset i_tready", 64'(ifc.i_tready), 64'd0);
        check("post-reset o_tvalid", 64'(ifc.o_tvalid), 64'd0);
        @(negedge bus_clk);
        check("first grant busy", 64'(busy), 64'd1);
        check("first grant port", 64'(grant_port), 64'd1);
        wait_drain("reset pkt", 50);
        repeat (2) tick();
        check("reset pkt_count", 64'(pkt_count), 64'd1);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            write_reg(SR, {28'd0, vec[t].mask});
            for (int n = 0; n < vec[t].npkts; n++)
                for (int k = 0; k < NI; k++)
                    if (vec[t].present[k]) queue_pkt(k, vec[t].beats, n);
            for (int k = 0; k < NI; k++) nid[k] = 0;
            for (int i = 0; i < vec[t].exp_n; i++) begin
                p = int'(vec[t].order[2*i +: 2]);
                expect_pkt(p, vec[t].beats, nid[p]);
                nid[p]++;
            end
            sc_first = -1;
            sc_last  = -1;
            wait_drain(vec[t].name, 300);
            repeat (3) tick();
            check($sformatf("%s pkt_count", vec[t].name), 64'(pkt_count), 64'(vec[t].exp_n));
            if (vec[t].exp_n > 0)
                check($sformatf("%s cycle span", vec[t].name), 64'(sc_last - sc_first + 1),
                      64'(vec[t].exp_n * (vec[t].beats + 1) - 1));
        end

        // Port 1 disabled on its second beat with back-pressure: packet completes, no regrant.
        do_reset();
        queue_pkt(1, 4, 0);
        queue_pkt(1, 4, 1);
        queue_pkt(2, 1, 0);
        expect_pkt(1, 4, 0);
        expect_pkt(2, 1, 0);
        wait_busy("mask mid-packet");
        tick();
        set_stb  = 1'b1;
        set_addr = SR;
        set_data = 32'hD;
        tick();
        set_stb = 1'b0;
        ifc.o_tready = 1'b0;
        tick();
        ifc.o_tready = 1'b1;
        tick();
        ifc.o_tready = 1'b0;
        tick();
        ifc.o_tready = 1'b1;
        wait_drain("mask mid-packet", 100);
        repeat (5) tick();
        @(negedge bus_clk);
        check("mask mid-packet pkt_count", 64'(pkt_count), 64'd2);
        check("port1 not regranted", 64'(port_q[1].size()), 64'd4);
        check("mask mid-packet last grant", 64'(grant_port), 64'd2);

        // Clear on the second beat of a port-3 packet.
        do_reset();
        queue_pkt(3, 4, 0);
        expect_beat(3, 0, 0, 1'b0);
        expect_beat(3, 0, 1, 1'b0);
        expect_pkt(0, 1, 0);
        expect_beat(3, 0, 2, 1'b0);
        expect_beat(3, 0, 3, 1'b1);
        wait_busy("clear mid-packet");
        tick();
        clear = 1'b1;
        queue_pkt(0, 1, 0);
        tick();
        clear = 1'b0;
        @(negedge bus_clk);
        check("clear busy", 64'(busy), 64'd0);
        check("clear i_tready", 64'(ifc.i_tready), 64'd0);
        check("clear o_tvalid", 64'(ifc.o_tvalid), 64'd0);
        check("clear pkt_count", 64'(pkt_count), 64'd0);
        @(negedge bus_clk);
        check("post-clear grant port", 64'(grant_port), 64'd0);
        wait_drain("clear mid-packet", 100);
        repeat (2) tick();
        check("post-clear pkt_count", 64'(pkt_count), 64'd2);

        // Packet counter wrap.
        do_reset();
        force dut.r_pkt_count = 32'hFFFF_FFFF;
        tick();
        release dut.r_pkt_count;
        queue_pkt(0, 2, 0);
        expect_pkt(0, 2, 0);
        wait_drain("wrap", 50);
        repeat (2) tick();
        check("pkt_count wrap", 64'(pkt_count), 64'd0);

        // Foreign addresses ignored; a write racing arbitration uses the old mask; clear keeps mask.
        do_reset();
        write_reg(8'h11, 32'h0);
        write_reg(8'h00, 32'h0);
        tick();
        set_stb  = 1'b1;
        set_addr = SR;
        set_data = 32'hE;
        queue_pkt(0, 1, 0);
        queue_pkt(0, 1, 1);
        expect_pkt(0, 1, 0);
        tick();
        set_stb = 1'b0;
        wait_drain("old mask", 50);
        repeat (5) tick();
        check("old mask pkt_count", 64'(pkt_count), 64'd1);
        check("new mask blocks port0", 64'(port_q[0].size()), 64'd1);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (6) tick();
        check("clear keeps mask pkt_count", 64'(pkt_count), 64'd0);
        check("clear keeps mask port0", 64'(port_q[0].size()), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/axi_pkt_rr_arbiter.md
AXI_PKT_RR_ARBITER -- requirements
Module: axi_pkt_rr_arbiter

Interface
REQ-001 Parameter NUM_INPUTS, default 4, number of requester ports; legal range 2..4.
REQ-002 Parameter WIDTH, default 64, tdata width.
REQ-003 Parameter SR_ENABLE, default 8'd0, settings address of the port-enable mask register.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 bus_clk  input  1  clock; all logic on rising edge.
REQ-006 bus_rst  input  1  synchronous active-high reset.
REQ-007 clear  input  1  synchronous soft clear.
REQ-008 set_stb  input  1  settings write strobe.
REQ-009 set_addr  input  8  settings address.
REQ-010 set_data  input  32  settings data.
REQ-011 i_tdata  input  NUM_INPUTS*WIDTH  flattened request data; port k at [k*WIDTH +: WIDTH].
REQ-012 i_tlast, i_tvalid  input  NUM_INPUTS each  per-port last and valid.
REQ-013 i_tready  output  NUM_INPUTS  per-port ready.
REQ-014 o_tdata  output  WIDTH  shared output data.
REQ-015 o_tlast, o_tvalid  output  1 each  shared output last and valid.
REQ-016 o_tready  input  1  downstream ready.
REQ-017 grant_port  output  2  index of the currently or last granted port.
REQ-018 busy  output  1  high in GRANT state.
REQ-019 pkt_count  output  32  count of completed output packets.

Function
REQ-020 The enable mask SHALL be NUM_INPUTS bits wide, loaded from set_data[NUM_INPUTS-1:0] when set_stb is high and set_addr == SR_ENABLE.
REQ-021 The FSM SHALL have two states: IDLE and GRANT.
REQ-022 In IDLE, candidates SHALL be the ports with i_tvalid & enable set.
REQ-023 In IDLE, if any candidate exists, the FSM SHALL select the first candidate, searching cyclically from last_grant+1 (mod NUM_INPUTS), register it into grant_port, and enter GRANT on the next edge.
REQ-024 Arbitration latency SHALL be one cycle: o_tvalid is never asserted in IDLE.
REQ-025 In IDLE, all i_tready bits SHALL be 0, o_tvalid 0, and o_tlast 0.
REQ-026 In GRANT, o_tdata, o_tlast and o_tvalid SHALL combinationally equal the signals of port grant_port.
REQ-027 In GRANT, i_tready[grant_port] SHALL equal o_tready and all other i_tready bits SHALL be 0.
REQ-028 In GRANT, a beat with o_tvalid & o_tready & o_tlast SHALL, on that edge, return the FSM to IDLE, set last_grant to grant_port, and increment pkt_count.
REQ-029 A back-to-back packet from any port therefore incurs exactly one idle cycle between its tlast beat and its next first beat.
REQ-030 Clearing a port's enable bit while that port is granted SHALL NOT abort the packet; the change affects only later arbitration.
REQ-031 A settings write and an arbitration decision in the same cycle SHALL use the old mask for that decision.
REQ-032 pkt_count SHALL wrap from 32'hFFFFFFFF to 0.
REQ-033 A single-beat packet (tlast on the first beat) SHALL be handled identically to longer packets.
REQ-034 A write to any address other than SR_ENABLE SHALL be ignored.
REQ-035 busy SHALL be high exactly when the state is GRANT.

Reset
REQ-036 On bus_rst the block SHALL set state to IDLE, last_grant to NUM_INPUTS-1 (so port 0 has first priority), grant_port to 0, pkt_count to 0, and the enable mask to all ones.
REQ-037 On clear the block SHALL behave as on bus_rst, except that the enable mask SHALL be retained.
REQ-038 A clear issued mid-packet SHALL drop the grant immediately; the remainder of that packet is discarded by the downstream.
REQ-039 During and one cycle after reset, all i_tready bits and o_tvalid SHALL be 0.

Verification
REQ-040 Scenario: reset, then ports 0–3 each present one 3-beat packet simultaneously with o_tready=1 -> output order 0,1,2,3; pkt_count=4; one idle cycle between packets.
REQ-041 Scenario: only port 2 streams 5 single-beat packets -> grant_port=2 throughout; output alternates beat/idle; pkt_count=5.
REQ-042 Scenario: write mask 4'b1010, then all ports valid -> only ports 1 and 3 are granted, alternating 1,3,1,3.
REQ-043 Scenario: port 1 granted; mask bit 1 cleared on its second beat; o_tready toggled 1,0,1 -> full 4-beat packet delivered with no beat lost or duplicated; port 1 is not granted again.
REQ-044 Scenario: clear asserted on the 2nd beat of a 4-beat packet from port 3 -> next cycle IDLE, i_tready=0, pkt_count=0; next arbitration starts at port 0.
REQ-045 Scenario: pkt_count forced to 32'hFFFFFFFF, then one packet completes -> pkt_count=0.
